// File: rtl/arb_mux_bus_pkg.sv
// arb_mux_bus shared definitions
// selection modes, output-register states, width helper
`timescale 1ns/1ps
package arb_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
  localparam int MODE_PRI = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // bits needed to index value items
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_bus_if.sv
// arb_mux_bus handshake bundle
// master drives requests, slave is the mux
`timescale 1ns/1ps
interface arb_mux_bus_if
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);

  localparam int SEL_W = clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data,
    output in_valid,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_src,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_src,
    output out_valid
  );

endinterface

// File: rtl/arb_mux_bus_arbiter.sv
// mux_rr_arbiter: combinational grant selection
// external select, round-robin or fixed priority
`timescale 1ns/1ps
module mux_rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int MODE   = MODE_SEL,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  rr_ptr,
  input  logic [SEL_W-1:0]  sel,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  localparam int EXT = 1 << SEL_W;

  logic [EXT-1:0] req_ext;
  int             idx;

  // pad requests so any select value indexes safely
  always_comb begin
    req_ext = '0;
    req_ext[NUM_IN-1:0] = req;
  end

  // pick one requester; descending scan leaves the nearest winner
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (MODE == MODE_RR) begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (req_ext[idx]) begin
          grant     = SEL_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end else if (MODE == MODE_PRI) begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (req_ext[k]) begin
          grant     = SEL_W'(k);
          grant_vld = 1'b1;
        end
      end
    end else begin
      grant     = sel;
      grant_vld = (int'(sel) < NUM_IN) && req_ext[sel];
    end
  end

endmodule

// File: rtl/arb_mux_bus.sv
// arb_mux_bus: N-input arbitrated mux
// one registered output stage, 1 word/cycle
`timescale 1ns/1ps
module arb_mux_bus
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = MODE_SEL
) (
  input  logic         clk,
  input  logic         rst_n,
  arb_mux_bus_if.slave bus
);

  localparam int SEL_W = clog2(NUM_IN);

  out_state_t       state;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] src_q;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  mux_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .MODE   (MODE)
  ) u_arb (
    .req       (bus.in_valid),
    .rr_ptr    (rr_ptr),
    .sel       (bus.sel),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  assign can_accept = (state == EMPTY) || bus.out_ready;
  assign xfer       = rst_n && grant_vld && can_accept;
  assign ptr_nxt    = (int'(grant) == NUM_IN - 1) ?
                      '0 : grant + 1'b1;

  // ready goes only to the granted channel
  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant] = 1'b1;
  end

  // route the granted channel's word
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i))
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // output register, fill/drain state and rr pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      data_q <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (xfer) begin
        data_q <= grant_data;
        src_q  <= grant;
        rr_ptr <= ptr_nxt;
      end
      unique case (state)
        EMPTY: if (xfer) state <= FULL;
        FULL:  if (!xfer && bus.out_ready) state <= EMPTY;
      endcase
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = (state == FULL);

endmodule

// File: tb/tb_arb_mux_bus.sv
// arb_mux_bus bench: directed scenarios plus
// randomized traffic against a queue-level model
`timescale 1ns/1ps
module tb_arb_mux_bus;
  import arb_mux_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arb_mux_bus_if #(.WIDTH(W), .NUM_IN(4)) bs ();
  arb_mux_bus_if #(.WIDTH(W), .NUM_IN(4)) br ();
  arb_mux_bus_if #(.WIDTH(W), .NUM_IN(4)) bp ();
  arb_mux_bus_if #(.WIDTH(W), .NUM_IN(3)) ts ();
  arb_mux_bus_if #(.WIDTH(W), .NUM_IN(3)) tr ();

  arb_mux_bus #(.WIDTH(W), .NUM_IN(4), .MODE(MODE_SEL))
    u_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  arb_mux_bus #(.WIDTH(W), .NUM_IN(4), .MODE(MODE_RR))
    u_r (.clk(clk), .rst_n(rst_n), .bus(br));
  arb_mux_bus #(.WIDTH(W), .NUM_IN(4), .MODE(MODE_PRI))
    u_p (.clk(clk), .rst_n(rst_n), .bus(bp));
  arb_mux_bus #(.WIDTH(W), .NUM_IN(3), .MODE(MODE_SEL))
    u_ts (.clk(clk), .rst_n(rst_n), .bus(ts));
  arb_mux_bus #(.WIDTH(W), .NUM_IN(3), .MODE(MODE_RR))
    u_tr (.clk(clk), .rst_n(rst_n), .bus(tr));

  // reference grant: -1 means nobody wins
  function automatic int ref_grant(input int mode, input int n,
                                   input logic [15:0] v,
                                   input int s, input int p);
    int best;
    int bd;
    best = -1;
    bd = n;
    if (mode == 0) return (s < n && v[s]) ? s : -1;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        if (mode == 2) return i;
        if (((i - p + n) % n) < bd) begin
          bd = (i - p + n) % n;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic idle_all();
    bs.in_valid = '0; bs.in_data = '0; bs.sel = '0; bs.out_ready = 1'b0;
    br.in_valid = '0; br.in_data = '0; br.sel = '0; br.out_ready = 1'b0;
    bp.in_valid = '0; bp.in_data = '0; bp.sel = '0; bp.out_ready = 1'b0;
    ts.in_valid = '0; ts.in_data = '0; ts.sel = '0; ts.out_ready = 1'b0;
    tr.in_valid = '0; tr.in_data = '0; tr.sel = '0; tr.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0]   ov;
    logic [17:0]  ordy;
    logic [9:0]   osrc;
    logic [W-1:0] od;
    rst_n = 1'b0;
    idle_all();
    bs.in_valid = '1; br.in_valid = '1; bp.in_valid = '1;
    ts.in_valid = '1; tr.in_valid = '1;
    bs.out_ready = 1'b1; br.out_ready = 1'b1; bp.out_ready = 1'b1;
    ts.out_ready = 1'b1; tr.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ov = {bs.out_valid, br.out_valid, bp.out_valid, ts.out_valid, tr.out_valid};
    ordy = {bs.in_ready, br.in_ready, bp.in_ready, ts.in_ready, tr.in_ready};
    osrc = {bs.out_src, br.out_src, bp.out_src, ts.out_src, tr.out_src};
    od = bs.out_data | br.out_data | bp.out_data | ts.out_data | tr.out_data;
    checks++;
    if (ov !== 5'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", ov);
    end
    checks++;
    if (ordy !== 18'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", ordy);
    end
    checks++;
    if (osrc !== 10'b0) begin
      errors++; $display("FAIL reset_src got %b want 0", osrc);
    end
    checks++;
    if (od !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", od);
    end
  endtask

  task automatic test_sel();
    do_reset();
    bs.sel = 2'd2;
    bs.in_valid = 4'b0100;
    bs.in_data = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
    bs.out_ready = 1'b1;
    #1;
    checks++;
    if (bs.in_ready !== 4'b0100) begin
      errors++; $display("FAIL sel_ready got %b want 0100", bs.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bs.out_data !== 32'hDEAD_BEEF || bs.out_src !== 2'd2 ||
        bs.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sel_out got %h/%0d/%b want deadbeef/2/1",
               bs.out_data, bs.out_src, bs.out_valid);
    end
    bs.sel = 2'd1;
    #1;
    checks++;
    if (bs.in_ready !== 4'b0000) begin
      errors++; $display("FAIL sel_idle_ready got %b want 0000", bs.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bs.out_valid !== 1'b0 || bs.out_data !== 32'hDEAD_BEEF ||
        bs.out_src !== 2'd2) begin
      errors++;
      $display("FAIL sel_drain got %b/%h/%0d want 0/deadbeef/2",
               bs.out_valid, bs.out_data, bs.out_src);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    int seq [4] = '{1, 3, 1, 3};
    do_reset();
    br.in_valid = 4'b1111;
    br.in_data = {32'd103, 32'd102, 32'd101, 32'd100};
    br.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      exp = k % 4;
      checks++;
      if (br.out_valid !== 1'b1 || int'(br.out_src) != exp ||
          br.out_data !== W'(100 + exp)) begin
        errors++;
        $display("FAIL rr_all step %0d got %b/%0d/%0d want 1/%0d/%0d",
                 k, br.out_valid, br.out_src, br.out_data, exp, 100 + exp);
      end
    end
    br.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (br.out_valid !== 1'b1 || int'(br.out_src) != seq[k]) begin
        errors++;
        $display("FAIL rr_pair step %0d got %b/%0d want 1/%0d",
                 k, br.out_valid, br.out_src, seq[k]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    bp.in_valid = 4'b1010;
    bp.in_data = {32'h33, 32'h0, 32'h11, 32'h0};
    bp.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bp.in_ready !== 4'b0010) begin
        errors++; $display("FAIL pri_ready got %b want 0010", bp.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bp.out_src !== 2'd1 || bp.out_data !== 32'h11 ||
          bp.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL pri_low got %0d/%h want 1/11", bp.out_src, bp.out_data);
      end
    end
    bp.in_valid = 4'b1000;
    @(posedge clk);
    #1;
    checks++;
    if (bp.out_src !== 2'd3 || bp.out_data !== 32'h33) begin
      errors++;
      $display("FAIL pri_hi got %0d/%h want 3/33", bp.out_src, bp.out_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bp.in_valid = 4'b0001;
    bp.in_data = {96'h0, 32'h0000_0055};
    bp.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bp.out_ready = 1'b0;
    bp.in_data = {96'h0, 32'h0000_00AA};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bp.in_ready !== 4'b0000) begin
        errors++; $display("FAIL stall_ready got %b want 0000", bp.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bp.out_data !== 32'h55 || bp.out_src !== 2'd0 ||
          bp.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got %h/%0d/%b want 55/0/1",
                 bp.out_data, bp.out_src, bp.out_valid);
      end
    end
    bp.out_ready = 1'b1;
    #1;
    checks++;
    if (bp.in_ready !== 4'b0001) begin
      errors++; $display("FAIL refill_ready got %b want 0001", bp.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bp.out_data !== 32'hAA || bp.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL refill got %h/%b want aa/1", bp.out_data, bp.out_valid);
    end
    bp.in_valid = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (bp.out_valid !== 1'b0 || bp.out_data !== 32'hAA) begin
      errors++;
      $display("FAIL drain got %b/%h want 0/aa", bp.out_valid, bp.out_data);
    end
  endtask

  task automatic test_num3();
    do_reset();
    ts.sel = 2'd3;
    ts.in_valid = 3'b111;
    ts.in_data = {32'h2, 32'h1, 32'h0};
    ts.out_ready = 1'b1;
    tr.in_valid = 3'b111;
    tr.in_data = {32'h2, 32'h1, 32'h0};
    tr.out_ready = 1'b1;
    #1;
    checks++;
    if (ts.in_ready !== 3'b000) begin
      errors++; $display("FAIL n3_sel_ready got %b want 000", ts.in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ts.out_valid !== 1'b0) begin
        errors++; $display("FAIL n3_sel_valid got %b want 0", ts.out_valid);
      end
      checks++;
      if (tr.out_valid !== 1'b1 || int'(tr.out_src) != k % 3 ||
          tr.out_data !== W'(k % 3)) begin
        errors++;
        $display("FAIL n3_rr step %0d got %b/%0d want 1/%0d",
                 k, tr.out_valid, tr.out_src, k % 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    br.in_valid = 4'b1111;
    br.in_data = {32'd103, 32'd102, 32'd101, 32'd100};
    br.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (br.out_valid !== 1'b1 || br.out_src !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre got %b/%0d want 1/1", br.out_valid, br.out_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (br.out_valid !== 1'b0 || br.out_data !== '0 || br.out_src !== '0 ||
        br.in_ready !== '0) begin
      errors++;
      $display("FAIL mid_async got %b/%h/%0d/%b want 0/0/0/0",
               br.out_valid, br.out_data, br.out_src, br.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (br.out_valid !== 1'b1 || br.out_src !== 2'd0 ||
        br.out_data !== 32'd100) begin
      errors++;
      $display("FAIL mid_restart got %b/%0d want 1/0", br.out_valid, br.out_src);
    end
  endtask

  task automatic test_random();
    int          md [5] = '{0, 1, 2, 0, 1};
    int          nn [5] = '{4, 4, 4, 3, 3};
    logic        ev [5];
    logic [W-1:0] ed [5];
    int          es [5];
    int          ptr [5];
    int          s [5];
    logic [3:0]  v [5];
    logic        r [5];
    logic [W-1:0] dw [4];
    logic [15:0] o_rdy;
    logic [15:0] e_rdy;
    logic        o_v;
    logic [W-1:0] o_d;
    int          o_s;
    int          g;
    logic        can;
    do_reset();
    for (int m = 0; m < 5; m++) begin
      ev[m] = 1'b0; ed[m] = '0; es[m] = 0; ptr[m] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 5; m++) begin
        case (m)
          0: begin o_v = bs.out_valid; o_d = bs.out_data; o_s = int'(bs.out_src); end
          1: begin o_v = br.out_valid; o_d = br.out_data; o_s = int'(br.out_src); end
          2: begin o_v = bp.out_valid; o_d = bp.out_data; o_s = int'(bp.out_src); end
          3: begin o_v = ts.out_valid; o_d = ts.out_data; o_s = int'(ts.out_src); end
          default: begin o_v = tr.out_valid; o_d = tr.out_data; o_s = int'(tr.out_src); end
        endcase
        checks++;
        if (o_v !== ev[m] || o_d !== ed[m] || o_s != es[m]) begin
          errors++;
          $display("FAIL rand_out dut %0d cyc %0d got %b/%h/%0d want %b/%h/%0d",
                   m, c, o_v, o_d, o_s, ev[m], ed[m], es[m]);
        end
      end
      for (int i = 0; i < 4; i++) dw[i] = W'($urandom);
      for (int m = 0; m < 5; m++) begin
        v[m] = 4'($urandom_range(0, 15));
        if (nn[m] == 3) v[m][3] = 1'b0;
        s[m] = $urandom_range(0, 3);
        r[m] = ($urandom_range(0, 3) != 0);
      end
      bs.in_valid = v[0]; bs.sel = 2'(s[0]); bs.out_ready = r[0];
      br.in_valid = v[1]; br.sel = 2'(s[1]); br.out_ready = r[1];
      bp.in_valid = v[2]; bp.sel = 2'(s[2]); bp.out_ready = r[2];
      ts.in_valid = v[3][2:0]; ts.sel = 2'(s[3]); ts.out_ready = r[3];
      tr.in_valid = v[4][2:0]; tr.sel = 2'(s[4]); tr.out_ready = r[4];
      bs.in_data = {dw[3], dw[2], dw[1], dw[0]};
      br.in_data = {dw[3], dw[2], dw[1], dw[0]};
      bp.in_data = {dw[3], dw[2], dw[1], dw[0]};
      ts.in_data = {dw[2], dw[1], dw[0]};
      tr.in_data = {dw[2], dw[1], dw[0]};
      #1;
      for (int m = 0; m < 5; m++) begin
        g = ref_grant(md[m], nn[m], 16'(v[m]), s[m], ptr[m]);
        can = !ev[m] || r[m];
        e_rdy = (g >= 0 && can) ? (16'd1 << g) : 16'd0;
        case (m)
          0: o_rdy = 16'(bs.in_ready);
          1: o_rdy = 16'(br.in_ready);
          2: o_rdy = 16'(bp.in_ready);
          3: o_rdy = 16'(ts.in_ready);
          default: o_rdy = 16'(tr.in_ready);
        endcase
        checks++;
        if (o_rdy !== e_rdy) begin
          errors++;
          $display("FAIL rand_ready dut %0d cyc %0d got %b want %b",
                   m, c, o_rdy, e_rdy);
        end
        if (g >= 0 && can) begin
          ev[m] = 1'b1;
          ed[m] = dw[g];
          es[m] = g;
          ptr[m] = (g + 1) % nn[m];
        end else if (ev[m] && r[m]) begin
          ev[m] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_sel();
    test_round_robin();
    test_priority();
    test_stall();
    test_num3();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
